// File: rtl/ps2_key_events_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key event front end.
//   - Prefix and discarded-byte constants.
//   - Event layout {ext, brk, code} and its width EV_W.
//   - Receiver FSM state type.
//   - is_discard(): true for keyboard status/response bytes that carry no key.
package ps2_pkg;

  localparam int unsigned EV_W = 10;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] B_BAT_OK   = 8'hAA;
  localparam logic [7:0] B_ACK      = 8'hFA;
  localparam logic [7:0] B_BAT_FAIL = 8'hFC;
  localparam logic [7:0] B_RESEND   = 8'hFE;
  localparam logic [7:0] B_ECHO     = 8'hEE;
  localparam logic [7:0] B_PAUSE    = 8'hE1;
  localparam logic [7:0] B_ERR_00   = 8'h00;
  localparam logic [7:0] B_ERR_FF   = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == B_BAT_OK) || (b == B_ACK) || (b == B_BAT_FAIL) ||
           (b == B_RESEND) || (b == B_ECHO) || (b == B_PAUSE) ||
           (b == B_ERR_00) || (b == B_ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_key_events_if.sv
// ps2_key_events_if: key event stream (valid/ready) from the PS/2 front end.
//   ev_valid : head event present        (master -> slave)
//   ev_ready : consumer accepts the head (slave -> master)
//   ev_code  : scancode without prefix   (master -> slave)
//   ev_ext   : event was E0-prefixed     (master -> slave)
//   ev_break : event is a key release    (master -> slave)
interface ps2_key_events_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_break,
                  input  ev_ready);
  modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_break,
                  output ev_ready);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 frame receiver on the system clock.
//   clk, rst      : system clock, synchronous active-high reset
//   ps2_clk_i     : raw PS/2 clock (asynchronous)
//   ps2_data_i    : raw PS/2 data (asynchronous)
//   byte_valid_o  : one-cycle pulse, byte_o holds a correctly framed byte
//   byte_o        : last received byte
//   frame_err_o   : one-cycle pulse on parity, stop-bit or timeout error
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic      clk_s1_q, clk_s2_q, clk_prev_q;
  logic      dat_s1_q, dat_s2_q;
  logic      fall;

  rx_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          err_q, err_d;

  // Synchronisers idle high so a reset with the line high creates no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    err_d        = 1'b0;

    if (state_q == RX_IDLE || fall) tmo_d = '0;
    else                            tmo_d = tmo_q + TW'(1);

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat_s2_q && (^{shreg_q, par_q})) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Counter reaches TIMEOUT_CYCLES-1 only after that many edge-free cycles.
    if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_events.sv
// ps2_key_events: PS/2 keyboard front end producing make/break key events.
//   clk, rst   : system clock, synchronous active-high reset
//   PS2Clk     : raw PS/2 clock (asynchronous)
//   PS2Data    : raw PS/2 data (asynchronous)
//   ev         : event stream (master side): ev_valid/ev_ready/ev_code/ev_ext/ev_break
//   frame_err  : one-cycle pulse on a receive error
//   overflow   : sticky, an event was dropped because the FIFO was full
//   held_count : occupied slots of the held-key table
module ps2_key_events
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned HELD_SLOTS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned REPORT_BREAK   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              PS2Clk,
  input  logic                              PS2Data,
  ps2_key_events_if.master                  ev,
  output logic                              frame_err,
  output logic                              overflow,
  output logic [$clog2(HELD_SLOTS+1)-1:0]   held_count
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned HC_W = $clog2(HELD_SLOTS + 1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (PS2Clk),
    .ps2_data_i   (PS2Data),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_err)
  );

  // ---------------- decoder ----------------
  logic       ext_pend_q, brk_pend_q;
  logic       ev_fire;
  ps2_event_t ev_new;
  logic [8:0] ev_key;

  always_comb begin
    ev_fire = rx_valid && (rx_byte != PFX_EXT) && (rx_byte != PFX_BRK) && !is_discard(rx_byte);
    ev_new  = '{ext: ext_pend_q, brk: brk_pend_q, code: rx_byte};
    ev_key  = {ext_pend_q, rx_byte};
  end

  always_ff @(posedge clk) begin
    if (rst || rx_err) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PFX_EXT) begin
        ext_pend_q <= 1'b1;
      end else if (rx_byte == PFX_BRK) begin
        brk_pend_q <= 1'b1;
      end else begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  // ---------------- held-key table ----------------
  logic [HELD_SLOTS-1:0] slot_vld_q, slot_vld_d, hit_vec, free_vec, alloc_vec;
  logic [8:0]            slot_key_q [HELD_SLOTS];
  logic                  key_wr, wr_req;

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < HELD_SLOTS; i++)
      hit_vec[i] = slot_vld_q[i] && (slot_key_q[i] == ev_key);
    free_vec  = ~slot_vld_q;
    // Isolate the lowest set bit: lowest free slot, or none when full.
    alloc_vec = free_vec & (~free_vec + HELD_SLOTS'(1));
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    wr_req     = 1'b0;
    key_wr     = 1'b0;
    if (ev_fire) begin
      if (ev_new.brk) begin
        slot_vld_d = slot_vld_q & ~hit_vec;
        wr_req     = (REPORT_BREAK != 0);
      end else if (hit_vec == '0) begin
        slot_vld_d = slot_vld_q | alloc_vec;
        key_wr     = 1'b1;
        wr_req     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slot_vld_q <= '0;
    else     slot_vld_q <= slot_vld_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < HELD_SLOTS; i++)
      if (key_wr && alloc_vec[i]) slot_key_q[i] <= ev_key;
  end

  always_comb begin
    held_count = '0;
    for (int unsigned i = 0; i < HELD_SLOTS; i++)
      held_count = held_count + HC_W'(slot_vld_q[i]);
  end

  // ---------------- event FIFO ----------------
  logic [EV_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            empty, full, pop, push;
  ps2_event_t      head;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = !empty && ev.ev_ready;
    // A same-cycle pop frees the slot the write needs.
    push  = wr_req && (!full || pop);
    head  = ps2_event_t'(mem_q[rd_ptr_q[AW-1:0]]);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= EV_W'(ev_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (wr_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign ev.ev_valid = !empty;
  assign ev.ev_code  = empty ? '0   : head.code;
  assign ev.ev_ext   = empty ? 1'b0 : head.ext;
  assign ev.ev_break = empty ? 1'b0 : head.brk;
  assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_events.sv
module tb_ps2_key_events;

  localparam int HALF  = 10;
  localparam int TMO   = 200;
  localparam int DEPTH = 8;
  localparam int SLOTS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       frame_err, overflow;
  logic [2:0] held_count;

  ps2_key_events_if ev_if ();

  ps2_key_events #(
    .FIFO_DEPTH     (DEPTH),
    .HELD_SLOTS     (SLOTS),
    .TIMEOUT_CYCLES (TMO),
    .REPORT_BREAK   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .ev         (ev_if),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .held_count (held_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed traffic
  logic [9:0] got_q[$];
  int         err_cnt = 0;

  always @(negedge clk) begin
    if (ev_if.ev_valid && ev_if.ev_ready)
      got_q.push_back({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    if (frame_err) err_cnt++;
  end

  // Reference model: keyboard byte stream -> expected event list
  logic [9:0] exp_q[$];
  logic [8:0] m_held[$];
  bit         m_ext, m_brk, m_ovf, hold_mode;
  int         m_occ;

  task automatic model_push(input logic [9:0] e);
    if (hold_mode && m_occ == DEPTH) m_ovf = 1'b1;
    else begin
      exp_q.push_back(e);
      if (hold_mode) m_occ++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] key;
    int idx;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b inside {8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF}) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      key = {m_ext, b};
      idx = -1;
      foreach (m_held[i]) if (m_held[i] == key) idx = i;
      if (m_brk) begin
        if (idx >= 0) m_held.delete(idx);
        model_push({m_ext, 1'b1, b});
      end else if (idx < 0) begin
        if (m_held.size() < SLOTS) m_held.push_back(key);
        model_push({m_ext, 1'b0, b});
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    m_ext = 1'b0; m_brk = 1'b0;
  endtask

  // Drive nbits of an 11-bit PS/2 frame. With pulse_ready, ev_ready is held
  // high for exactly the cycle in which the stop-bit byte is written.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit pulse_ready);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 PS2Data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 PS2Clk = 1'b0;
      if (pulse_ready && i == 10) begin
        repeat (3) @(posedge clk);
        #1 ev_if.ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_if.ev_ready = 1'b0;
        repeat (HALF - 4) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 PS2Clk = 1'b1;
    end
    @(posedge clk); #1 PS2Data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    model_byte(b);
    repeat (HALF) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ev_if.ev_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ev_if.ev_valid); end
    checks++;
    if ({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code} !== 10'h000) begin
      errors++; $display("FAIL rst_head got %h exp 000", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    end
    checks++;
    if ({frame_err, overflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {frame_err, overflow}); end
    checks++;
    if (held_count !== 3'd0) begin errors++; $display("FAIL rst_held got %0d exp 0", held_count); end
  endtask

  task automatic test_make_break();
    send_key(8'h1C);
    checks++;
    if (held_count !== 3'd1) begin errors++; $display("FAIL mb_held_make got %0d exp 1", held_count); end
    send_key(8'hF0);
    send_key(8'h1C);
    checks++;
    if (held_count !== 3'd0) begin errors++; $display("FAIL mb_held_break got %0d exp 0", held_count); end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 10'h01C || got_q[1] !== 10'h11C) begin
      errors++; $display("FAIL mb_events got n=%0d exp 01C,11C", got_q.size());
    end
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL mb_model got n=%0d exp n=%0d", got_q.size(), exp_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_extended();
    send_key(8'hE0); send_key(8'h75);
    checks++;
    if (held_count !== 3'd1) begin errors++; $display("FAIL ext_held got %0d exp 1", held_count); end
    send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 10'h275 || got_q[1] !== 10'h375) begin
      errors++; $display("FAIL ext_events got n=%0d exp 275,375", got_q.size());
    end
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL ext_model got n=%0d exp n=%0d", got_q.size(), exp_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_typematic();
    for (int i = 0; i < 5; i++) send_key(8'h1D);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL typ_make_count got %0d exp 1", got_q.size()); end
    send_key(8'hF0); send_key(8'h1D);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 10'h01D || got_q[1] !== 10'h11D) begin
      errors++; $display("FAIL typ_events got n=%0d exp 01D,11D", got_q.size());
    end
    checks++;
    if (held_count !== 3'd0) begin errors++; $display("FAIL typ_held got %0d exp 0", held_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_errors();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0); model_err();
    repeat (HALF) @(posedge clk);
    checks++;
    if (err_cnt != e0 + 1) begin errors++; $display("FAIL perr_pulses got %0d exp 1", err_cnt - e0); end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL perr_noevent got %0d exp 0", got_q.size()); end
    // A bad frame after F0 must cancel the pending release.
    send_key(8'hF0);
    send_frame(8'h33, 1'b1, 11, 1'b0); model_err();
    repeat (HALF) @(posedge clk);
    send_key(8'h1C);
    send_key(8'hF0); send_key(8'h1C);
    // Start bit plus 4 data bits, then the clock stalls high.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    repeat (150) @(posedge clk);
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL tmo_early got %0d exp 0", err_cnt - e0); end
    repeat (110) @(posedge clk);
    checks++;
    if (err_cnt != e0 + 1) begin errors++; $display("FAIL tmo_pulse got %0d exp 1", err_cnt - e0); end
    model_err();
    send_key(8'h1C);
    send_key(8'hF0); send_key(8'h1C);
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 10'h01C || got_q[2] !== 10'h01C) begin
      errors++; $display("FAIL err_events got n=%0d exp 01C,11C,01C,11C", got_q.size());
    end
    checks++;
    if (got_q != exp_q) begin errors++; $display("FAIL err_model got n=%0d exp n=%0d", got_q.size(), exp_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] keys [5];
    logic [7:0] disc [3];
    int e0, m_errs, r;
    keys = '{8'h1C, 8'h1D, 8'h75, 8'h6B, 8'h12};
    disc = '{8'hAA, 8'hFA, 8'hEE};
    e0 = err_cnt; m_errs = 0;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 1) == 1) send_key(8'hE0);
        if ($urandom_range(0, 1) == 1) send_key(8'hF0);
        send_key(keys[$urandom_range(0, 4)]);
      end else if (r == 6) begin
        send_key(disc[$urandom_range(0, 2)]);
      end else if (r == 7) begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 11, 1'b0); model_err(); m_errs++;
        repeat (HALF) @(posedge clk);
      end else if (r == 8) begin
        send_key($urandom_range(0, 1) == 1 ? 8'hE0 : 8'hF0);
        send_key(disc[$urandom_range(0, 2)]);
        send_key(keys[$urandom_range(0, 4)]);
      end else begin
        send_key(8'hF0);
        send_frame(8'($urandom_range(0, 255)), 1'b1, 11, 1'b0); model_err(); m_errs++;
        repeat (HALF) @(posedge clk);
        send_key(keys[$urandom_range(0, 4)]);
      end
      checks++;
      if (held_count !== 3'(m_held.size())) begin
        errors++; $display("FAIL rnd_held[%0d] got %0d exp %0d", it, held_count, m_held.size());
      end
    end
    checks++;
    if (err_cnt - e0 != m_errs) begin errors++; $display("FAIL rnd_errs got %0d exp %0d", err_cnt - e0, m_errs); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_event[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    // Release everything still held so later scenarios start clean.
    while (m_held.size() > 0) begin
      if (m_held[0][8]) send_key(8'hE0);
      send_key(8'hF0);
      send_key(m_held[0][7:0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] ks [10];
    ks = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4B};
    ev_if.ev_ready = 1'b0;
    hold_mode = 1'b1; m_occ = 0; m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) send_key(ks[i]);
    checks++;
    if ({ev_if.ev_valid, overflow} !== 2'b10) begin errors++; $display("FAIL ovf_fill got %b exp 10", {ev_if.ev_valid, overflow}); end
    checks++;
    if (ev_if.ev_code !== 8'h15) begin errors++; $display("FAIL ovf_head got %h exp 15", ev_if.ev_code); end
    checks++;
    if (held_count !== 3'(SLOTS)) begin errors++; $display("FAIL ovf_held got %0d exp %0d", held_count, SLOTS); end
    // Write into a full FIFO in the same cycle as a pop.
    send_frame(ks[8], 1'b0, 11, 1'b1);
    m_occ--;
    model_byte(ks[8]);
    repeat (HALF) @(posedge clk);
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_samecycle got %b exp %b", overflow, m_ovf); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h015) begin errors++; $display("FAIL ovf_pop1 got n=%0d exp 015", got_q.size()); end
    send_key(ks[9]);
    checks++;
    if (overflow !== 1'b1 || m_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    #1 ev_if.ev_ready = 1'b1;
    repeat (20) @(posedge clk);
    hold_mode = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++;
    if ({ev_if.ev_valid, overflow} !== 2'b01) begin errors++; $display("FAIL ovf_drain got %b exp 01", {ev_if.ev_valid, overflow}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    int e0;
    ev_if.ev_ready = 1'b0;
    send_key(8'h5A);
    send_key(8'hE0);
    send_frame(8'h1C, 1'b0, 6, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_held.delete(); exp_q.delete(); got_q.delete(); model_err();
    e0 = err_cnt;
    @(negedge clk);
    checks++;
    if ({ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code} !== 11'h000) begin
      errors++; $display("FAIL mrst_head got %h exp 000", {ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    end
    checks++;
    if ({frame_err, overflow, held_count} !== 5'd0) begin
      errors++; $display("FAIL mrst_flags got %b exp 00000", {frame_err, overflow, held_count});
    end
    #1 ev_if.ev_ready = 1'b1;
    repeat (TMO + 20) @(posedge clk);
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL mrst_spurious_err got %0d exp 0", err_cnt - e0); end
    send_key(8'h1C);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin errors++; $display("FAIL mrst_next got n=%0d exp 01C", got_q.size()); end
    checks++;
    if (held_count !== 3'd1) begin errors++; $display("FAIL mrst_held got %0d exp 1", held_count); end
  endtask

  initial begin
    ev_if.ev_ready = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; hold_mode = 1'b0; m_occ = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_frame_errors();
    test_random();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Parametrised PS/2 keyboard front end for the game input path: receives PS/2 frames directly on the system clock, checks framing and parity, resolves E0/F0 prefixes into make/break events with an extended flag, and suppresses typematic repeats. Events are buffered in a small FIFO with a valid/ready handshake. It sits between the board PS/2 pins and the game controller. It also covers key release, arrow/extended keys and several keys held at once.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, 2 to 64.
- `HELD_SLOTS`, default 4: number of simultaneously held keys tracked for repeat suppression; 1 to 8.
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles mid-frame before the frame is abandoned (1 ms at 100 MHz).
- `REPORT_BREAK`, default 1: 1 enqueues break events; 0 drops them, but they still update the held table.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst` input, 1 bit: synchronous, active-high reset.
- `PS2Clk` input, 1 bit: raw PS/2 clock, asynchronous.
- `PS2Data` input, 1 bit: raw PS/2 data, asynchronous.
- `ev_valid` output, 1 bit: FIFO head holds an event.
- `ev_ready` input, 1 bit: consumer accepts the head event when `ev_valid` is also high.
- `ev_code` output, 8 bits: scancode of the head event, without its prefix.
- `ev_ext` output, 1 bit: head event was E0-prefixed.
- `ev_break` output, 1 bit: head event is a release.
- `frame_err` output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.
- `overflow` output, 1 bit: sticky; set when an event is dropped because the FIFO is full.
- `held_count` output, $clog2(HELD_SLOTS+1) bits: number of occupied held-table slots.

## Operation
- **Input sync:** `PS2Clk` and `PS2Data` each pass through 2-FF synchronisers. A falling edge is detected on the synced clock. Data is sampled on that edge.
- **Receiver FSM, IDLE:** a falling edge with data 0 moves to DATA with bit count 0. A falling edge with data 1 is ignored.
- **Receiver FSM, DATA:** takes 8 bits, LSB first, then moves to PARITY.
- **Receiver FSM, PARITY → STOP → IDLE:** the byte is valid only if parity is odd over data plus parity bit and the stop bit is 1.
- **Receiver timeout:** in any state other than IDLE, `TIMEOUT_CYCLES` cycles without an edge returns the FSM to IDLE and pulses `frame_err`.
- **Decoder, prefixes:** a valid byte of 0xE0 sets `ext_pend`. A valid byte of 0xF0 sets `brk_pend`.
- **Decoder, discarded bytes:** valid bytes 0xAA, 0xFA, 0xFC, 0xFE, 0xEE, 0xE1, 0x00 and 0xFF are discarded and clear both pending flags.
- **Decoder, scancodes:** any other valid byte produces the event {`ext_pend`, `brk_pend`, byte}, then clears both pending flags.
- **Decoder, errors:** a frame error also clears both pending flags.
- **Held table, make event:**
  - Key already held, matched on {ext, code}: the event is dropped as a typematic repeat.
  - Key not held: it goes into the lowest free slot and the event is enqueued.
  - Table full: the event is enqueued and the key is not tracked.
- **Held table, break event:** the matching slot is freed, if there is one. The event is enqueued when `REPORT_BREAK` is 1, matched or not.
- **FIFO:** first-word fall-through; the head is visible whenever `ev_valid` is high.
  - Pop happens on `ev_valid && ev_ready`.
  - A write while full drops the new event and sets `overflow`. The exception: a same-cycle pop makes room, so the write succeeds and `overflow` stays unchanged.
  - `ev_ready` while empty has no effect.

## Timing
- **Reset values:**
  - `ev_valid`, `frame_err`, `overflow` and `held_count` are 0.
  - `ev_code`, `ev_ext` and `ev_break` are 0.
  - The FIFO is emptied, the held table cleared, the pending flags cleared and the receiver set to IDLE.
- **Reset mid-frame:** partial bits are discarded. The next frame is accepted only from a fresh start bit.
- **Latency:**
  - Cycle N: stop-bit falling edge detected.
  - N+1: byte decoded and held-table lookup performed.
  - N+2: event written; `ev_valid` is high at N+2 if the FIFO was empty.
- **Input delay:** 2 cycles of synchroniser delay come before edge detection.
- **`frame_err`:** asserted for exactly one cycle, at N+1 for parity or stop errors, and on the timeout cycle for timeouts.
- **Held-table update:** `held_count` changes in the same cycle as the event write.
- **Rate:** a PS/2 byte takes at least about 550 µs, so the decoder never sees back-to-back bytes.

## Structure
- **Package `ps2_pkg`:**
  - Constants for the prefixes and discarded bytes (0xE0, 0xF0, 0xAA, 0xFA, …).
  - An event struct or width constant (`EV_W` = 10: ext, brk, code).
  - The receiver state enum.
- **Sub-module `ps2_rx_frame`:** synchronisers, edge detector, receiver FSM and timeout counter.
  - Outputs `byte_valid`, `byte`, `frame_err`.
- **Top level:** holds the decoder, held table and FIFO. The FIFO is inline: an array plus read/write pointers with an extra wrap bit.

## Test plan
- **Plain make/break:** frames 0x1C, then F0 1C → two events, {0,0,0x1C} and {0,1,0x1C}; `held_count` goes 1 then 0.
- **Extended key:** E0 75 then E0 F0 75 → {1,0,0x75} and {1,1,0x75}; no event for any prefix byte.
- **Typematic repeat:** 0x1D sent 5 times, then F0 1D → exactly one make and one break event.
- **Frame errors:**
  - A bad-parity frame gives one `frame_err` pulse and no event.
  - PS2Clk stalled after 4 bits gives `frame_err` at the timeout, and the following 0x1C decodes correctly.
- **Overflow with `ev_ready`=0 (FIFO_DEPTH 8):** 9 distinct makes → 8 events held and `overflow`=1.
  - Pop all → codes come out in send order.
  - Write and pop in the same cycle while full → no overflow.
- **Reset mid-frame:** assert `rst` after 6 bits of a frame → all outputs return to reset values, and the next full 0x1C frame decodes.
